// File: rtl/ysyx_24090018_ifu.sv
// Instruction fetch unit: owns the PC, issues one instruction-memory fetch at
// a time and holds the returned word for decode until decode accepts it.
//
// Handshake rules: a transfer happens on a rising edge where valid and ready
// are both 1. The producer keeps valid and its payload stable until that
// edge. The consumer's ready may depend on valid. Neither side withdraws
// valid before the transfer.
//
// state_o exports the FSM state for observation:
// 0 = REQ, 1 = WAIT, 2 = HOLD.
module ysyx_24090018_ifu #(
  parameter int unsigned                DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]      RESET_PC   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid_o,
  input  logic                  imem_req_ready_i,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  imem_rsp_err_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic                  inst_fault_o,
  input  logic                  npc_valid_i,
  input  logic [DATA_WIDTH-1:0] npc_i,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nx;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] inst_q;
  logic                  fault_q;
  logic                  dec_hs;
  logic [DATA_WIDTH-1:0] pc_seq;
  logic [DATA_WIDTH-1:0] pc_redirect;

  // Decode takes the held instruction on this edge.
  assign dec_hs      = (state == ST_HOLD) && inst_ready_i;
  // Sequential successor wraps modulo 2^DATA_WIDTH.
  assign pc_seq      = pc + DATA_WIDTH'(4);
  // Redirect targets are silently word-aligned; no trap is raised here.
  assign pc_redirect = npc_i & ~(DATA_WIDTH'(3));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_REQ;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: request, wait for the response, hold until decode takes it.
  always_comb begin
    state_nx = state;
    case (state)
      ST_REQ:  if (imem_req_ready_i) state_nx = ST_WAIT;
      ST_WAIT: if (imem_rsp_valid_i) state_nx = ST_HOLD;
      ST_HOLD: if (inst_ready_i)     state_nx = ST_REQ;
      default: state_nx = ST_REQ;
    endcase
  end

  // Output decode: valids come only from the registered state, masked during reset.
  always_comb begin
    imem_req_valid_o = 1'b0;
    inst_valid_o     = 1'b0;
    if (!rst) begin
      imem_req_valid_o = (state == ST_REQ);
      inst_valid_o     = (state == ST_HOLD);
    end
  end

  // PC advances only when decode accepts the instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (dec_hs) begin
      pc <= npc_valid_i ? pc_redirect : pc_seq;
    end
  end

  // Capture the response word and its fault flag; they stay stable through HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q  <= '0;
      fault_q <= 1'b0;
    end else if ((state == ST_WAIT) && imem_rsp_valid_i) begin
      inst_q  <= imem_rdata_i;
      fault_q <= imem_rsp_err_i;
    end
  end

  assign imem_addr_o  = pc;
  assign pc_o         = pc;
  assign inst_o       = inst_q;
  assign inst_fault_o = fault_q;
  assign state_o      = state;

endmodule

// File: tb/tb_ysyx_24090018_ifu.sv
// Bench for ysyx_24090018_ifu: a randomized memory/decode driver pushes each
// response it issues into exp_q. A monitor keeps a transaction-level model
// (PC value, request outstanding, response received) and checks every cycle.
module tb_ysyx_24090018_ifu;

  localparam int          W        = 32;
  localparam logic [W-1:0] RESET_PC = 32'h8000_0000;
  localparam int          N_CYC    = 3000;

  logic         clk;
  logic         rst;
  logic         imem_req_valid_o;
  logic         imem_req_ready_i;
  logic [W-1:0] imem_addr_o;
  logic         imem_rsp_valid_i;
  logic [W-1:0] imem_rdata_i;
  logic         imem_rsp_err_i;
  logic         inst_valid_o;
  logic         inst_ready_i;
  logic [W-1:0] inst_o;
  logic [W-1:0] pc_o;
  logic         inst_fault_o;
  logic         npc_valid_i;
  logic [W-1:0] npc_i;
  logic [1:0]   state_o;

  int checks    = 0;
  int failures  = 0;
  int delivered = 0;
  int wraps     = 0;
  int redirs    = 0;
  int cyc       = 0;
  bit directed  = 1'b0;
  bit done      = 1'b0;

  // Expected {fault, instruction} per issued response, oldest first.
  logic [W:0] exp_q[$];

  ysyx_24090018_ifu #(.DATA_WIDTH(W), .RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_addr_o      (imem_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rdata_i     (imem_rdata_i),
    .imem_rsp_err_i   (imem_rsp_err_i),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready_i),
    .inst_o           (inst_o),
    .pc_o             (pc_o),
    .inst_fault_o     (inst_fault_o),
    .npc_valid_i      (npc_valid_i),
    .npc_i            (npc_i),
    .state_o          (state_o)
  );

  // Clock and reset-free clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver: instruction memory and decode/execute stimulus, changed on negedges.
  initial begin
    int rst_left;
    int dly;
    int stall_left;
    bit pending;
    bit did_wait_rst;
    bit did_hold_rst;
    bit did_stall;
    rst_left = 3; dly = 0; stall_left = 0; pending = 0;
    did_wait_rst = 0; did_hold_rst = 0; did_stall = 0;
    rst = 1'b1;
    imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b0; imem_rdata_i = '0;
    imem_rsp_err_i = 1'b0; inst_ready_i = 1'b0; npc_valid_i = 1'b0; npc_i = '0;
    for (int c = 0; c < N_CYC; c++) begin
      @(negedge clk);
      cyc      = c;
      directed = (c >= 4 && c < 16);
      imem_rsp_valid_i = 1'b0;
      imem_rdata_i     = $urandom;
      imem_rsp_err_i   = 1'($urandom_range(0, 1));
      // Mid-transaction resets: once while waiting for memory, once while holding.
      if (!did_wait_rst && c >= 300 && pending) begin
        rst_left = 2; did_wait_rst = 1;
      end
      if (!did_hold_rst && c >= 600 && !rst && inst_valid_o) begin
        rst_left = 2; did_hold_rst = 1;
      end
      if (rst_left > 0) begin
        rst = 1'b1; rst_left--; pending = 0;
        imem_req_ready_i = 1'b0; inst_ready_i = 1'b0; npc_valid_i = 1'b0;
        continue;
      end
      if (rst) begin
        rst = 1'b0;
        imem_req_ready_i = 1'b0; inst_ready_i = 1'b0; npc_valid_i = 1'b0;
        continue;
      end
      // Memory response, at least one cycle after acceptance.
      if (pending) begin
        if (dly == 0) begin
          imem_rsp_valid_i = 1'b1;
          if (directed) begin
            imem_rdata_i   = 32'h0010_0093;
            imem_rsp_err_i = 1'b0;
          end else begin
            imem_rsp_err_i = ($urandom_range(0, 3) == 0);
          end
          exp_q.push_back({imem_rsp_err_i, imem_rdata_i});
          pending = 0;
        end else begin
          dly--;
        end
      end else if (!directed && imem_req_valid_o) begin
        // Stray response while a request is pending acceptance; must be ignored.
        imem_rsp_valid_i = 1'($urandom_range(0, 1));
      end
      imem_req_ready_i = directed ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (imem_req_valid_o && imem_req_ready_i) begin
        pending = 1;
        dly     = directed ? 0 : $urandom_range(0, 3);
      end
      if (!did_stall && c >= 50 && inst_valid_o) begin
        stall_left = 5; did_stall = 1;
      end
      if (stall_left > 0) begin
        inst_ready_i = 1'b0;
        stall_left--;
      end else begin
        inst_ready_i = directed ? 1'b1 : ($urandom_range(0, 2) != 0);
      end
      npc_valid_i = directed ? 1'b0 : 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       npc_i = 32'h8000_0103;
        1:       npc_i = 32'hFFFF_FFFC;
        2:       npc_i = 32'hFFFF_FFFF;
        default: npc_i = $urandom;
      endcase
    end
    done = 1'b1;
  end

  // Monitor: transaction-level reference model, compared every cycle.
  initial begin
    logic [W-1:0] model_pc;
    logic [W:0]   e;
    bit outstanding;
    bit got_rsp;
    bit after_rst;
    int n_acc;
    int last_hs;
    model_pc = RESET_PC; outstanding = 0; got_rsp = 0; after_rst = 0;
    n_acc = 0; last_hs = -1;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        check("req_valid_in_rst", 32'(imem_req_valid_o), 32'd0);
        check("inst_valid_in_rst", 32'(inst_valid_o), 32'd0);
        exp_q.delete();
        model_pc = RESET_PC; outstanding = 0; got_rsp = 0; after_rst = 1;
        n_acc = 0; last_hs = -1;
      end else begin
        if (after_rst) begin
          check("inst_after_rst", inst_o, 32'd0);
          check("fault_after_rst", 32'(inst_fault_o), 32'd0);
          after_rst = 0;
        end
        check("pc", pc_o, model_pc);
        check("imem_addr", imem_addr_o, model_pc);
        check("req_valid", 32'(imem_req_valid_o), 32'(!outstanding));
        check("inst_valid", 32'(inst_valid_o), 32'(got_rsp));
        if (got_rsp) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL exp_q_empty: got inst %h with no expected entry (cycle %0d)", inst_o, cyc);
          end else begin
            e = exp_q[0];
            check("inst", inst_o, e[W-1:0]);
            check("fault", 32'(inst_fault_o), 32'(e[W]));
          end
        end
        if (got_rsp && inst_ready_i) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          delivered++;
          if (directed && last_hs >= 0) check("hs_gap", 32'(cyc - last_hs), 32'd3);
          last_hs = cyc;
          if (npc_valid_i) begin
            if (npc_i == 32'h8000_0103) redirs++;
            model_pc = npc_i & ~32'h3;
          end else begin
            if (model_pc == 32'hFFFF_FFFC) wraps++;
            model_pc = model_pc + 32'd4;
          end
          outstanding = 0; got_rsp = 0;
        end else if (outstanding && !got_rsp && imem_rsp_valid_i) begin
          got_rsp = 1;
        end else if (!outstanding && imem_req_ready_i) begin
          if (directed && n_acc < 4)
            check("directed_addr", imem_addr_o, RESET_PC + 32'(4 * n_acc));
          n_acc++;
          outstanding = 1;
        end
      end
    end
  end

  // Final report.
  initial begin
    wait (done);
    @(negedge clk);
    #2;
    check("delivered_enough", 32'(delivered >= 100), 32'd1);
    check("wrap_seen", 32'(wraps >= 1), 32'd1);
    check("redirect_0103_seen", 32'(redirs >= 1), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
